// File: rtl/reset_sequencer.sv
// Reset/enable sequencer: debounces a push-button, merges it with a software
// request, holds every channel in reset, then releases and enables channels
// one at a time in ascending order. Also counts accepted reset events.
module reset_sequencer #(
    parameter int unsigned CH_NUM         = 2,
    parameter int unsigned HOLD_COUNT     = 1000,
    parameter int unsigned STAGE_DELAY    = 100,
    parameter int unsigned DEBOUNCE_COUNT = 16,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic              clk,
    input  logic              reset_in,
    input  logic              key_n_in,
    input  logic              soft_reset_req,
    output logic [CH_NUM-1:0] reset_out,
    output logic [CH_NUM-1:0] en_out,
    output logic              ready,
    output logic [7:0]        reset_cnt
);

    // One counter serves both the hold and the stage delay, so it covers the larger.
    localparam int unsigned CNT_MAX = (HOLD_COUNT > STAGE_DELAY) ? HOLD_COUNT : STAGE_DELAY;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX);
    localparam int unsigned DB_W    = (DEBOUNCE_COUNT > 1) ? $clog2(DEBOUNCE_COUNT) : 1;
    localparam int unsigned STG_W   = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

    typedef enum logic [1:0] {
        ST_HOLD  = 2'd0,
        ST_STAGE = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [DB_W-1:0]        db_cnt_q, db_cnt_d;
    logic                   key_pressed_q, key_pressed_d;
    logic                   req_q, req_d;
    logic                   req_c;
    logic                   key_sync_n;
    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [STG_W-1:0]       stage_q, stage_d;
    logic [CH_NUM-1:0]      reset_out_q, reset_out_d;
    logic [CH_NUM-1:0]      en_q, en_d;
    logic                   ready_q, ready_d;
    logic [7:0]             reset_cnt_q, reset_cnt_d;

    // Synchroniser shift chain for the asynchronous push-button.
    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], key_n_in};
        key_sync_n = sync_q[SYNC_STAGES-1];
    end

    // Debounce: flip the accepted key level only after a run of mismatching cycles.
    always_comb begin
        db_cnt_d      = '0;
        key_pressed_d = key_pressed_q;
        if ((~key_sync_n) != key_pressed_q) begin
            if (db_cnt_q == DB_W'(DEBOUNCE_COUNT - 1)) begin
                key_pressed_d = ~key_sync_n;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end
    end

    // Combined restart request; a rising edge is one counted event.
    always_comb begin
        req_c       = key_pressed_q | soft_reset_req;
        req_d       = req_c;
        reset_cnt_d = reset_cnt_q;
        if (req_c && !req_q && (reset_cnt_q != 8'hFF)) begin
            reset_cnt_d = reset_cnt_q + 8'd1;
        end
    end

    // Sequencer next state: any request forces full HOLD entry, otherwise time the steps.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        stage_d     = stage_q;
        reset_out_d = reset_out_q;
        en_d        = en_q;
        ready_d     = ready_q;
        if (req_c) begin
            state_d     = ST_HOLD;
            cnt_d       = '0;
            stage_d     = '0;
            reset_out_d = '1;
            en_d        = '0;
            ready_d     = 1'b0;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    if (cnt_q == CNT_W'(HOLD_COUNT - 1)) begin
                        reset_out_d[0] = 1'b0;
                        state_d        = ST_STAGE;
                        cnt_d          = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_STAGE: begin
                    if (cnt_q == CNT_W'(STAGE_DELAY - 1)) begin
                        cnt_d = '0;
                        for (int unsigned k = 0; k < CH_NUM; k++) begin
                            if (stage_q == STG_W'(k)) begin
                                en_d[k] = 1'b1;
                            end
                        end
                        if (stage_q == STG_W'(CH_NUM - 1)) begin
                            ready_d = 1'b1;
                            state_d = ST_RUN;
                        end else begin
                            for (int unsigned k = 1; k < CH_NUM; k++) begin
                                if (stage_q == STG_W'(k - 1)) begin
                                    reset_out_d[k] = 1'b0;
                                end
                            end
                            stage_d = stage_q + STG_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    state_d = ST_RUN;
                end
                default: begin
                    state_d     = ST_HOLD;
                    cnt_d       = '0;
                    stage_d     = '0;
                    reset_out_d = '1;
                    en_d        = '0;
                    ready_d     = 1'b0;
                end
            endcase
        end
    end

    // State and output registers; reset_in forces the safe state immediately.
    always_ff @(posedge clk or posedge reset_in) begin
        if (reset_in) begin
            sync_q        <= '1;
            db_cnt_q      <= '0;
            key_pressed_q <= 1'b0;
            req_q         <= 1'b0;
            state_q       <= ST_HOLD;
            cnt_q         <= '0;
            stage_q       <= '0;
            reset_out_q   <= '1;
            en_q          <= '0;
            ready_q       <= 1'b0;
            reset_cnt_q   <= '0;
        end else begin
            sync_q        <= sync_d;
            db_cnt_q      <= db_cnt_d;
            key_pressed_q <= key_pressed_d;
            req_q         <= req_d;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            stage_q       <= stage_d;
            reset_out_q   <= reset_out_d;
            en_q          <= en_d;
            ready_q       <= ready_d;
            reset_cnt_q   <= reset_cnt_d;
        end
    end

    assign reset_out = reset_out_q;
    assign en_out    = en_q;
    assign ready     = ready_q;
    assign reset_cnt = reset_cnt_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with CH_NUM=3, HOLD=8, STAGE=4, DEBOUNCE=4.
module tb_reset_sequencer;

    localparam int CH    = 3;
    localparam int HOLD  = 8;
    localparam int STAGE = 4;
    localparam int DB    = 4;
    localparam int SYNC  = 2;

    localparam logic [6:0] OUT_RESET = 7'b111_000_0;
    localparam logic [6:0] OUT_RUN   = 7'b000_111_1;

    logic          clk = 1'b0;
    logic          reset_in;
    logic          key_n_in;
    logic          soft_reset_req;
    logic [CH-1:0] reset_out;
    logic [CH-1:0] en_out;
    logic          ready;
    logic [7:0]    reset_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_cnt  = 0;

    always #5 clk = ~clk;

    reset_sequencer #(
        .CH_NUM(CH), .HOLD_COUNT(HOLD), .STAGE_DELAY(STAGE),
        .DEBOUNCE_COUNT(DB), .SYNC_STAGES(SYNC)
    ) dut (
        .clk(clk), .reset_in(reset_in), .key_n_in(key_n_in),
        .soft_reset_req(soft_reset_req), .reset_out(reset_out),
        .en_out(en_out), .ready(ready), .reset_cnt(reset_cnt)
    );

    // Expected {reset_out, en_out, ready} k clocks after the first req-free HOLD cycle.
    function automatic logic [6:0] exp_out(input int k);
        logic [CH-1:0] r;
        logic [CH-1:0] e;
        logic          rd;
        for (int j = 0; j < CH; j++) begin
            r[j] = (k < HOLD + j * STAGE);
            e[j] = (k >= HOLD + (j + 1) * STAGE);
        end
        rd = (k >= HOLD + CH * STAGE);
        return {r, e, rd};
    endfunction

    task automatic test_reset();
        logic [6:0] obs;
        reset_in = 1'b1; key_n_in = 1'b1; soft_reset_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        obs = {reset_out, en_out, ready};
        n_checks++;
        if (obs !== OUT_RESET) begin n_fail++; $display("FAIL reset_hold: got %b want %b", obs, OUT_RESET); end
        n_checks++;
        if (reset_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_cnt_zero: got %0d want 0", reset_cnt); end
        @(negedge clk) reset_in = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            @(posedge clk); #1;
            obs = {reset_out, en_out, ready};
            n_checks++;
            if (obs !== exp_out(k)) begin n_fail++; $display("FAIL first_seq k=%0d: got %b want %b", k, obs, exp_out(k)); end
        end
        n_checks++;
        if (reset_cnt !== 8'd0) begin n_fail++; $display("FAIL first_seq_cnt: got %0d want 0", reset_cnt); end
    endtask

    task automatic test_soft_reset();
        logic [6:0] obs;
        @(negedge clk) soft_reset_req = 1'b1;
        @(posedge clk); #1;
        exp_cnt++;
        obs = {reset_out, en_out, ready};
        n_checks++;
        if (obs !== OUT_RESET) begin n_fail++; $display("FAIL soft_entry: got %b want %b", obs, OUT_RESET); end
        n_checks++;
        if (reset_cnt !== 8'(exp_cnt)) begin n_fail++; $display("FAIL soft_cnt: got %0d want %0d", reset_cnt, exp_cnt); end
        @(negedge clk) soft_reset_req = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            @(posedge clk); #1;
            obs = {reset_out, en_out, ready};
            n_checks++;
            if (obs !== exp_out(k)) begin n_fail++; $display("FAIL soft_seq k=%0d: got %b want %b", k, obs, exp_out(k)); end
        end
    endtask

    task automatic test_key_debounce();
        logic [6:0] obs;
        logic [6:0] want;
        // Three low cycles are one short of acceptance.
        for (int i = 0; i < 3; i++) @(negedge clk) key_n_in = 1'b0;
        @(negedge clk) key_n_in = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            obs = {reset_out, en_out, ready};
            n_checks++;
            if (obs !== OUT_RUN) begin n_fail++; $display("FAIL short_press i=%0d: got %b want %b", i, obs, OUT_RUN); end
        end
        n_checks++;
        if (reset_cnt !== 8'(exp_cnt)) begin n_fail++; $display("FAIL short_press_cnt: got %0d want %0d", reset_cnt, exp_cnt); end
        // Long press with a 2-cycle release glitch early on: one event, takes effect after the 11th edge.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk) key_n_in = (i == 2 || i == 3) ? 1'b1 : 1'b0;
            @(posedge clk); #1;
            want = (i <= 9) ? OUT_RUN : OUT_RESET;
            obs = {reset_out, en_out, ready};
            n_checks++;
            if (obs !== want) begin n_fail++; $display("FAIL long_press i=%0d: got %b want %b", i, obs, want); end
        end
        exp_cnt++;
        n_checks++;
        if (reset_cnt !== 8'(exp_cnt)) begin n_fail++; $display("FAIL long_press_cnt: got %0d want %0d", reset_cnt, exp_cnt); end
        // Release needs 2 sync + 4 debounce edges before HOLD starts counting.
        @(negedge clk) key_n_in = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            obs = {reset_out, en_out, ready};
            n_checks++;
            if (obs !== OUT_RESET) begin n_fail++; $display("FAIL release_wait i=%0d: got %b want %b", i, obs, OUT_RESET); end
        end
        for (int k = 1; k <= 24; k++) begin
            @(posedge clk); #1;
            obs = {reset_out, en_out, ready};
            n_checks++;
            if (obs !== exp_out(k)) begin n_fail++; $display("FAIL key_seq k=%0d: got %b want %b", k, obs, exp_out(k)); end
        end
    endtask

    task automatic test_abort();
        logic [6:0] obs;
        @(negedge clk) soft_reset_req = 1'b1;
        @(negedge clk) soft_reset_req = 1'b0;
        exp_cnt++;
        for (int k = 1; k <= 13; k++) begin
            @(posedge clk); #1;
            obs = {reset_out, en_out, ready};
            n_checks++;
            if (obs !== exp_out(k)) begin n_fail++; $display("FAIL abort_pre k=%0d: got %b want %b", k, obs, exp_out(k)); end
        end
        n_checks++;
        if (obs !== 7'b100_001_0) begin n_fail++; $display("FAIL abort_stage1: got %b want 1000010", obs); end
        @(negedge clk) soft_reset_req = 1'b1;
        @(posedge clk); #1;
        exp_cnt++;
        obs = {reset_out, en_out, ready};
        n_checks++;
        if (obs !== OUT_RESET) begin n_fail++; $display("FAIL abort_entry: got %b want %b", obs, OUT_RESET); end
        @(negedge clk) soft_reset_req = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            @(posedge clk); #1;
            obs = {reset_out, en_out, ready};
            n_checks++;
            if (obs !== exp_out(k)) begin n_fail++; $display("FAIL abort_seq k=%0d: got %b want %b", k, obs, exp_out(k)); end
        end
        n_checks++;
        if (reset_cnt !== 8'(exp_cnt)) begin n_fail++; $display("FAIL abort_cnt: got %0d want %0d", reset_cnt, exp_cnt); end
    endtask

    task automatic test_held_request();
        logic [6:0] obs;
        @(negedge clk) soft_reset_req = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            obs = {reset_out, en_out, ready};
            n_checks++;
            if (obs !== OUT_RESET) begin n_fail++; $display("FAIL held_req i=%0d: got %b want %b", i, obs, OUT_RESET); end
        end
        exp_cnt++;
        n_checks++;
        if (reset_cnt !== 8'(exp_cnt)) begin n_fail++; $display("FAIL held_cnt: got %0d want %0d", reset_cnt, exp_cnt); end
        @(negedge clk) soft_reset_req = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            @(posedge clk); #1;
            obs = {reset_out, en_out, ready};
            n_checks++;
            if (obs !== exp_out(k)) begin n_fail++; $display("FAIL held_seq k=%0d: got %b want %b", k, obs, exp_out(k)); end
        end
    endtask

    task automatic test_saturate();
        for (int p = 0; p < 300; p++) begin
            @(negedge clk) soft_reset_req = 1'b1;
            @(negedge clk) soft_reset_req = 1'b0;
            exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
            n_checks++;
            if (reset_cnt !== 8'(exp_cnt)) begin n_fail++; $display("FAIL saturate p=%0d: got %0d want %0d", p, reset_cnt, exp_cnt); end
        end
    endtask

    task automatic test_async_reset();
        logic [6:0] obs;
        for (int k = 1; k <= 14; k++) begin
            @(posedge clk); #1;
            obs = {reset_out, en_out, ready};
            n_checks++;
            if (obs !== exp_out(k)) begin n_fail++; $display("FAIL async_pre k=%0d: got %b want %b", k, obs, exp_out(k)); end
        end
        #2 reset_in = 1'b1;
        #1;
        exp_cnt = 0;
        obs = {reset_out, en_out, ready};
        n_checks++;
        if (obs !== OUT_RESET) begin n_fail++; $display("FAIL async_assert: got %b want %b", obs, OUT_RESET); end
        n_checks++;
        if (reset_cnt !== 8'd0) begin n_fail++; $display("FAIL async_cnt: got %0d want 0", reset_cnt); end
        @(negedge clk) reset_in = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            @(posedge clk); #1;
            obs = {reset_out, en_out, ready};
            n_checks++;
            if (obs !== exp_out(k)) begin n_fail++; $display("FAIL async_seq k=%0d: got %b want %b", k, obs, exp_out(k)); end
        end
        n_checks++;
        if (reset_cnt !== 8'd0) begin n_fail++; $display("FAIL async_seq_cnt: got %0d want 0", reset_cnt); end
    endtask

    initial begin
        test_reset();
        test_soft_reset();
        test_key_debounce();
        test_abort();
        test_held_request();
        test_saturate();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
